aes_round_engine: RTL and testbench

AES_ROUND_ENGINE -- requirements
Module: aes_round_engine

---
 rtl/aes_round_engine.sv | 162 ++++++++++++++++
 tb/tb_aes_round_engine.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_engine.sv
// Iterative AES encryption core: one cipher round per clock, with the round key supplied
// externally for the index shown on round_idx. The ciphertext is held until the handshake.
module aes_round_engine #(
  parameter int unsigned KEY_BITS    = 128,
  parameter int unsigned ROUND_IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   in_ready,
  input  logic [127:0]           plain_text,
  input  logic [127:0]           round_key,
  output logic [ROUND_IDX_W-1:0] round_idx,
  output logic                   busy,
  output logic [127:0]           enc_data,
  output logic                   valid_flag,
  input  logic                   out_ready
);

  localparam int unsigned NR = (KEY_BITS == 128) ? 10 :
                               (KEY_BITS == 192) ? 12 :
                               (KEY_BITS == 256) ? 14 : 0;
  localparam logic [ROUND_IDX_W-1:0] LAST_MID_IDX = ROUND_IDX_W'(NR - 1);
  localparam logic [ROUND_IDX_W-1:0] IDX_ONE      = ROUND_IDX_W'(1);

  if (NR == 0) begin : g_bad_key_bits
    $fatal(1, "aes_round_engine: KEY_BITS must be 128, 192 or 256");
  end
  if (ROUND_IDX_W < 4) begin : g_bad_idx_w
    $fatal(1, "aes_round_engine: ROUND_IDX_W must be at least 4");
  end

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUNDS,
    S_FINAL,
    S_DONE
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] x3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  state_e                 state_q, state_d;
  logic [ROUND_IDX_W-1:0] idx_q, idx_d;
  logic [127:0]           st_q, st_d;
  logic [127:0]           enc_q, enc_d;
  logic                   valid_q, valid_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;

  logic [7:0]   sub_b [16];
  logic [7:0]   shf_b [16];
  logic [127:0] shf_w;
  logic [127:0] mix_w;

  // Byte i of the 128-bit word sits at bits [127-8i -: 8]; state byte i is row i%4, column i/4.
  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sub_b[i] = SBOX[st_q[127-8*i -: 8]];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shf_b[4*c+r]             = sub_b[4*((c+r)%4)+r];
      assign shf_w[127-8*(4*c+r) -: 8] = shf_b[4*c+r];
    end
    assign mix_w[127-8*(4*c+0) -: 8] = xtime(shf_b[4*c]) ^ x3(shf_b[4*c+1]) ^ shf_b[4*c+2] ^ shf_b[4*c+3];
    assign mix_w[127-8*(4*c+1) -: 8] = shf_b[4*c] ^ xtime(shf_b[4*c+1]) ^ x3(shf_b[4*c+2]) ^ shf_b[4*c+3];
    assign mix_w[127-8*(4*c+2) -: 8] = shf_b[4*c] ^ shf_b[4*c+1] ^ xtime(shf_b[4*c+2]) ^ x3(shf_b[4*c+3]);
    assign mix_w[127-8*(4*c+3) -: 8] = x3(shf_b[4*c]) ^ shf_b[4*c+1] ^ shf_b[4*c+2] ^ xtime(shf_b[4*c+3]);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    st_d    = st_q;
    enc_d   = enc_q;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          st_d    = plain_text ^ round_key;
          idx_d   = IDX_ONE;
          state_d = S_ROUNDS;
        end
      end
      S_ROUNDS: begin
        st_d  = mix_w ^ round_key;
        idx_d = idx_q + IDX_ONE;
        if (idx_q == LAST_MID_IDX) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        enc_d   = shf_w ^ round_key;
        valid_d = 1'b1;
        idx_d   = '0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Status flags are registered from the next state so they line up with state_q.
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d == S_ROUNDS) || (state_d == S_FINAL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      st_q       <= '0;
      enc_q      <= '0;
      valid_q    <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      st_q       <= st_d;
      enc_q      <= enc_d;
      valid_q    <= valid_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign round_idx  = idx_q;
  assign enc_data   = enc_q;
  assign valid_flag = valid_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: three instances (128/192/256-bit keys) driven by known-answer
// and random blocks, compared against a byte-level AES model with a derived S-box.
module tb_aes_round_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start_s    [3];
  logic         in_ready_s [3];
  logic [127:0] pt_s       [3];
  logic [127:0] rk_s       [3];
  logic [3:0]   idx_s      [3];
  logic         busy_s     [3];
  logic [127:0] enc_s      [3];
  logic         valid_s    [3];
  logic         ordy_s     [3];

  logic [127:0] ks [3][16];
  logic [7:0]   sbox_m [256];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign rk_s[g] = ks[g][idx_s[g]];
    aes_round_engine #(.KEY_BITS(128 + 64*g), .ROUND_IDX_W(4)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_s[g]),
      .in_ready   (in_ready_s[g]),
      .plain_text (pt_s[g]),
      .round_key  (rk_s[g]),
      .round_idx  (idx_s[g]),
      .busy       (busy_s[g]),
      .enc_data   (enc_s[g]),
      .valid_flag (valid_s[g]),
      .out_ready  (ordy_s[g])
    );
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] v, input int i);
    return 8'(v >> (8 * (15 - i)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input int k, input logic [255:0] key);
    int nk, nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    nk = 4 + 2*k;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = 32'(key >> (32 * (7 - i)));
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      ks[k][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] aes_ref(input int k, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] v;
    int nr;
    nr = 10 + 2*k;
    for (int i = 0; i < 16; i++) s[i] = get_byte(pt, i) ^ get_byte(ks[k][0], i);
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int row = 0; row < 4; row++) a[row] = s[4*c+row];
          for (int row = 0; row < 4; row++)
            s[4*c+row] = gf_mul(8'h02, a[row]) ^ gf_mul(8'h03, a[(row+1)%4]) ^ a[(row+2)%4] ^ a[(row+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= get_byte(ks[k][r], i);
    end
    v = '0;
    for (int i = 0; i < 16; i++) v = {v[119:0], s[i]};
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Runs one block on instance k; hold = cycles of out_ready low after valid appears.
  task automatic run_block(input int k, input logic [127:0] pt, input logic [255:0] key,
                           input int hold, input bit keep_start, input bit rst_at_done);
    int nr;
    logic [127:0] exp_ct;
    nr = 10 + 2*k;
    expand(k, key);
    exp_ct = aes_ref(k, pt);
    ordy_s[k]  = (hold == 0);
    pt_s[k]    = pt;
    start_s[k] = 1'b1;
    check_eq($sformatf("k%0d in_ready idle", k), 128'(in_ready_s[k]), 128'(1));
    @(posedge clk); #1;
    if (!keep_start) start_s[k] = 1'b0;
    pt_s[k] = rand128();
    check_eq($sformatf("k%0d idx after accept", k), 128'(idx_s[k]), 128'(1));
    check_eq($sformatf("k%0d busy after accept", k), 128'(busy_s[k]), 128'(1));
    check_eq($sformatf("k%0d in_ready after accept", k), 128'(in_ready_s[k]), 128'(0));
    for (int j = 1; j <= nr; j++) begin
      @(posedge clk); #1;
      if (j < nr) begin
        check_eq($sformatf("k%0d idx edge %0d", k, j), 128'(idx_s[k]), 128'(j + 1));
        check_eq($sformatf("k%0d valid early edge %0d", k, j), 128'(valid_s[k]), 128'(0));
        check_eq($sformatf("k%0d busy edge %0d", k, j), 128'(busy_s[k]), 128'(1));
      end else begin
        check_eq($sformatf("k%0d valid at NR", k), 128'(valid_s[k]), 128'(1));
        check_eq($sformatf("k%0d ciphertext", k), enc_s[k], exp_ct);
        check_eq($sformatf("k%0d idx at done", k), 128'(idx_s[k]), 128'(0));
        check_eq($sformatf("k%0d busy at done", k), 128'(busy_s[k]), 128'(0));
      end
    end
    if (rst_at_done) begin
      reset = 1'b1;
      ordy_s[k] = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      ordy_s[k] = 1'b0;
      start_s[k] = 1'b0;
      check_eq($sformatf("k%0d rst+hs enc", k), enc_s[k], 128'h0);
      check_eq($sformatf("k%0d rst+hs valid", k), 128'(valid_s[k]), 128'(0));
      check_eq($sformatf("k%0d rst+hs in_ready", k), 128'(in_ready_s[k]), 128'(1));
      return;
    end
    for (int h = 0; h < hold; h++) begin
      if (!keep_start) start_s[k] = (h % 2 == 0);
      @(posedge clk); #1;
      check_eq($sformatf("k%0d hold valid %0d", k, h), 128'(valid_s[k]), 128'(1));
      check_eq($sformatf("k%0d hold enc %0d", k, h), enc_s[k], exp_ct);
      check_eq($sformatf("k%0d hold in_ready %0d", k, h), 128'(in_ready_s[k]), 128'(0));
      check_eq($sformatf("k%0d hold idx %0d", k, h), 128'(idx_s[k]), 128'(0));
    end
    ordy_s[k] = 1'b1;
    @(posedge clk); #1;
    ordy_s[k] = 1'b0;
    if (!keep_start) start_s[k] = 1'b0;
    check_eq($sformatf("k%0d valid after hs", k), 128'(valid_s[k]), 128'(0));
    check_eq($sformatf("k%0d in_ready after hs", k), 128'(in_ready_s[k]), 128'(1));
    check_eq($sformatf("k%0d enc retained", k), enc_s[k], exp_ct);
  endtask

  localparam logic [255:0] KEY_SEQ = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_SEQ  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      pt_s[k]    = '0;
      ordy_s[k]  = 1'b0;
      for (int r = 0; r < 16; r++) ks[k][r] = '0;
    end
    build_sbox();
    @(posedge clk);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("k%0d reset in_ready", k), 128'(in_ready_s[k]), 128'(1));
      check_eq($sformatf("k%0d reset busy", k), 128'(busy_s[k]), 128'(0));
      check_eq($sformatf("k%0d reset valid", k), 128'(valid_s[k]), 128'(0));
      check_eq($sformatf("k%0d reset enc", k), enc_s[k], 128'h0);
      check_eq($sformatf("k%0d reset idx", k), 128'(idx_s[k]), 128'(0));
    end
    reset = 1'b0;

    run_block(0, 128'h3243f6a8885a308d313198a2e0370734,
              {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0, 1'b0, 1'b0);
    check_eq("kat128 fips", enc_s[0], 128'h3925841d02dc09fbdc118597196a0b32);
    run_block(0, PT_SEQ, {KEY_SEQ[255:128], 128'h0}, 5, 1'b0, 1'b0);
    check_eq("kat128 seq", enc_s[0], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run_block(1, PT_SEQ, {KEY_SEQ[255:64], 64'h0}, 1, 1'b0, 1'b0);
    check_eq("kat192", enc_s[1], 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    run_block(2, PT_SEQ, KEY_SEQ, 2, 1'b0, 1'b0);
    check_eq("kat256", enc_s[2], 128'h8ea2b7ca516745bfeafc49904b496089);

    // Reset in the middle of the round sequence.
    expand(0, {rand128(), rand128()});
    pt_s[0] = rand128();
    ordy_s[0] = 1'b1;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("midround idx before reset", 128'(idx_s[0]), 128'(5));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ordy_s[0] = 1'b0;
    check_eq("midround rst idx", 128'(idx_s[0]), 128'(0));
    check_eq("midround rst enc", enc_s[0], 128'h0);
    check_eq("midround rst valid", 128'(valid_s[0]), 128'(0));
    check_eq("midround rst busy", 128'(busy_s[0]), 128'(0));
    check_eq("midround rst in_ready", 128'(in_ready_s[0]), 128'(1));
    run_block(0, rand128(), {rand128(), rand128()}, 0, 1'b0, 1'b0);

    // Reset and start together in IDLE: reset must win.
    reset = 1'b1;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start_s[0] = 1'b0;
    check_eq("rst+start in_ready", 128'(in_ready_s[0]), 128'(1));
    check_eq("rst+start busy", 128'(busy_s[0]), 128'(0));
    check_eq("rst+start idx", 128'(idx_s[0]), 128'(0));

    run_block(0, rand128(), {rand128(), rand128()}, 0, 1'b0, 1'b1);

    // Back-to-back with start held high through both blocks.
    run_block(0, rand128(), {rand128(), rand128()}, 0, 1'b1, 1'b0);
    run_block(0, rand128(), {rand128(), rand128()}, 0, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++)
      for (int n = 0; n < 4; n++)
        run_block(k, rand128(), {rand128(), rand128()}, int'($urandom_range(0, 3)), 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
